// File: rtl/env_pkg.sv
// env_pkg: envelope and sequencer state types plus the shared rate prescaler table.
package env_pkg;
   typedef enum logic [2:0] {ENV_IDLE, ATTACK, DECAY, SUSTAIN, RELEASE} env_state_e;
   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_UPDATE, S_DONE} seq_state_e;
   localparam logic [15:0] RATE_LUT [16] = '{
      16'd1, 16'd2, 16'd3, 16'd4, 16'd6, 16'd9, 16'd11, 16'd12,
      16'd15, 16'd38, 16'd75, 16'd122, 16'd156, 16'd469, 16'd781, 16'd1250
   };
endpackage

// File: rtl/env_step.sv
// env_step: combinational ADSR step for one voice; ENV_EXP_DECAY_EN selects level-scaled decay/release periods.
module env_step
   import env_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             gate,
   input  logic             prev_gate,
   input  logic [7:0]       ad,
   input  logic [7:0]       sr,
   input  env_state_e       st,
   input  logic [7:0]       lvl,
   input  logic [CNT_W-1:0] cnt,
   output env_state_e       st_n,
   output logic [7:0]       lvl_n,
   output logic [CNT_W-1:0] cnt_n
);
   logic [CNT_W-1:0] lut_a, lut_r, lin, slow, period, cnt_inc;
   logic [7:0] ss, up, dn;
   logic hit, active;
   assign lut_a = CNT_W'(RATE_LUT[ad[7:4]]);
   assign lut_r = CNT_W'(RATE_LUT[st == DECAY ? ad[3:0] : sr[3:0]]);
   assign lin = (lut_r << 1) + lut_r;
`ifdef ENV_EXP_DECAY_EN
   logic [CNT_W+4:0] x, m;
   assign x = {5'd0, lin};
   assign m = lvl > 8'd93 ? x : lvl > 8'd54 ? x << 1 : lvl > 8'd26 ? x << 2 :
              lvl > 8'd14 ? x << 3 : lvl > 8'd6 ? x << 4 : (x << 4) + (x << 3) + (x << 2) + (x << 1);
   assign slow = |m[CNT_W+4:CNT_W] ? '1 : m[CNT_W-1:0];
`else
   assign slow = lin;
`endif
   assign period = st == ATTACK ? lut_a : slow;
   assign ss = {sr[7:4], sr[7:4]};
   assign up = &lvl ? lvl : lvl + 8'd1;
   assign dn = lvl == 8'd0 ? lvl : lvl - 8'd1;
   assign cnt_inc = &cnt ? cnt : cnt + CNT_W'(1);
   assign active = st inside {ATTACK, DECAY, RELEASE};
   assign hit = cnt >= period - CNT_W'(1);
   always_comb begin
      st_n = st;
      lvl_n = lvl;
      cnt_n = active && hit ? '0 : cnt_inc;
      if (gate && !prev_gate) begin
         st_n = ATTACK;
         cnt_n = '0;
      end else if (!gate && prev_gate) begin
         st_n = RELEASE;
         cnt_n = '0;
      end else if (st == ATTACK) begin
         lvl_n = hit ? up : lvl;
         st_n = &lvl_n ? DECAY : ATTACK;
      end else if (st == DECAY) begin
         lvl_n = hit && lvl > ss ? dn : lvl;
         st_n = lvl_n <= ss ? SUSTAIN : DECAY;
      end else if (st == SUSTAIN) begin
         st_n = lvl > ss ? DECAY : SUSTAIN;
      end else if (st == RELEASE) begin
         lvl_n = hit ? dn : lvl;
         st_n = lvl_n == 8'd0 ? ENV_IDLE : RELEASE;
      end
   end
endmodule

// File: rtl/env_scheduler.sv
// env_scheduler: per-tick ADSR sequencer over all voices; ENV_EXP_DECAY_EN enables exponential-style decay in env_step.
module env_scheduler
   import env_pkg::*;
#(
   parameter int NUM_VOICES = 16,
   parameter int CNT_W      = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             sample_tick_i,
   input  logic [15:0][7:0] control_i,
   input  logic [15:0][7:0] ad_i,
   input  logic [15:0][7:0] sr_i,
   input  logic [3:0]       voice_idx_i,
   output logic [7:0]       env_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             overrun_o
);
   localparam logic [3:0] LAST = 4'(NUM_VOICES - 1);
   env_state_e st_q [16];
   logic [7:0] lvl_q [16];
   logic [CNT_W-1:0] cnt_q [16];
   logic [15:0] prev_q;
   seq_state_e seq;
   logic [3:0] ptr;
   logic pending;
   logic f_gate, f_prev;
   logic [7:0] f_ad, f_sr, f_lvl;
   env_state_e f_st;
   logic [CNT_W-1:0] f_cnt;
   env_state_e n_st;
   logic [7:0] n_lvl;
   logic [CNT_W-1:0] n_cnt;
   logic ctl_unused;
   assign ctl_unused = ^control_i;
   assign env_o = lvl_q[voice_idx_i];
   env_step #(.CNT_W(CNT_W)) u_step (
      .gate(f_gate), .prev_gate(f_prev), .ad(f_ad), .sr(f_sr),
      .st(f_st), .lvl(f_lvl), .cnt(f_cnt),
      .st_n(n_st), .lvl_n(n_lvl), .cnt_n(n_cnt)
   );
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < 16; i++) begin
            st_q[i] <= ENV_IDLE;
            lvl_q[i] <= '0;
            cnt_q[i] <= '0;
         end
         prev_q <= '0;
         seq <= S_IDLE;
         ptr <= '0;
         pending <= 1'b0;
         busy_o <= 1'b0;
         done_o <= 1'b0;
         overrun_o <= 1'b0;
         f_gate <= 1'b0;
         f_prev <= 1'b0;
         f_ad <= '0;
         f_sr <= '0;
         f_lvl <= '0;
         f_st <= ENV_IDLE;
         f_cnt <= '0;
      end else begin
         done_o <= seq == S_DONE;
         overrun_o <= sample_tick_i && seq != S_IDLE && pending;
         if (sample_tick_i && seq != S_IDLE)
            pending <= 1'b1;
         case (seq)
            S_IDLE: if (sample_tick_i || pending) begin
               ptr <= '0;
               pending <= 1'b0;
               busy_o <= 1'b1;
               seq <= S_FETCH;
            end
            S_FETCH: begin
               f_gate <= control_i[ptr][0];
               f_prev <= prev_q[ptr];
               f_ad <= ad_i[ptr];
               f_sr <= sr_i[ptr];
               f_lvl <= lvl_q[ptr];
               f_st <= st_q[ptr];
               f_cnt <= cnt_q[ptr];
               seq <= S_UPDATE;
            end
            S_UPDATE: begin
               st_q[ptr] <= n_st;
               lvl_q[ptr] <= n_lvl;
               cnt_q[ptr] <= n_cnt;
               prev_q[ptr] <= f_gate;
               ptr <= ptr == LAST ? ptr : ptr + 4'd1;
               seq <= ptr == LAST ? S_DONE : S_FETCH;
            end
            default: begin
               busy_o <= 1'b0;
               seq <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_env_scheduler.sv
// tb_env_scheduler: directed and randomized checks of env_scheduler against a per-voice envelope model.
module tb_env_scheduler;
   localparam int LUT [16] = '{1, 2, 3, 4, 6, 9, 11, 12, 15, 38, 75, 122, 156, 469, 781, 1250};
   logic clk = 1'b0;
   logic rst, tick;
   logic [15:0][7:0] control, ad, sr;
   logic [3:0] vidx;
   logic [7:0] env;
   logic busy, done, over;
   int checks = 0;
   int failures = 0;
   int m_lvl [16];
   int m_ph [16];
   int m_cnt [16];
   bit m_prev [16];
   always #10 clk = ~clk;
   env_scheduler #(.NUM_VOICES(16), .CNT_W(16)) dut (
      .clk_i(clk), .rst_i(rst), .sample_tick_i(tick),
      .control_i(control), .ad_i(ad), .sr_i(sr), .voice_idx_i(vidx),
      .env_o(env), .busy_o(busy), .done_o(done), .overrun_o(over)
   );
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask
   function automatic int period(input int v);
      int p;
      p = m_ph[v] == 1 ? LUT[ad[v][7:4]] : 3 * LUT[m_ph[v] == 2 ? ad[v][3:0] : sr[v][3:0]];
`ifdef ENV_EXP_DECAY_EN
      if (m_ph[v] != 1) begin
         p = p * (m_lvl[v] > 93 ? 1 : m_lvl[v] > 54 ? 2 : m_lvl[v] > 26 ? 4 :
                  m_lvl[v] > 14 ? 8 : m_lvl[v] > 6 ? 16 : 30);
         if (p > 65535) p = 65535;
      end
`endif
      return p;
   endfunction
   task automatic mstep(input int v);
      bit g, hit;
      int ss;
      g = control[v][0];
      ss = int'(sr[v][7:4]) * 17;
      if (g && !m_prev[v]) begin
         m_ph[v] = 1;
         m_cnt[v] = 0;
      end else if (!g && m_prev[v]) begin
         m_ph[v] = 4;
         m_cnt[v] = 0;
      end else begin
         hit = (m_ph[v] == 1 || m_ph[v] == 2 || m_ph[v] == 4) && m_cnt[v] >= period(v) - 1;
         m_cnt[v] = hit ? 0 : (m_cnt[v] < 65535 ? m_cnt[v] + 1 : 65535);
         case (m_ph[v])
            1: begin
               if (hit && m_lvl[v] < 255) m_lvl[v]++;
               if (m_lvl[v] == 255) m_ph[v] = 2;
            end
            2: begin
               if (hit && m_lvl[v] > ss) m_lvl[v]--;
               if (m_lvl[v] <= ss) m_ph[v] = 3;
            end
            3: if (m_lvl[v] > ss) m_ph[v] = 2;
            4: begin
               if (hit && m_lvl[v] > 0) m_lvl[v]--;
               if (m_lvl[v] == 0) m_ph[v] = 0;
            end
            default: ;
         endcase
      end
      m_prev[v] = g;
   endtask
   task automatic model_pass();
      for (int v = 0; v < 16; v++) mstep(v);
   endtask
   task automatic model_reset();
      for (int v = 0; v < 16; v++) begin
         m_lvl[v] = 0;
         m_ph[v] = 0;
         m_cnt[v] = 0;
         m_prev[v] = 0;
      end
   endtask
   task automatic check_all(input string tag);
      for (int v = 0; v < 16; v++) begin
         vidx = 4'(v);
         #1;
         check($sformatf("%s_v%0d", tag, v), {24'd0, env}, m_lvl[v]);
      end
   endtask
   task automatic read_v3(input string tag, input int exp);
      vidx = 4'd3;
      #1;
      check(tag, {24'd0, env}, exp);
   endtask
   task automatic do_pass();
      bit ok;
      ok = 0;
      tick = 1'b1;
      for (int c = 1; c <= 100; c++) begin
         @(posedge clk);
         #1;
         if (c == 1) tick = 1'b0;
         if (done) begin
            ok = 1;
            break;
         end
      end
      check("pass_done", 32'(ok), 1);
      model_pass();
      check_all("lvl");
   endtask
   task automatic window(input int t2, input int t3, output int dn, output int ov);
      dn = 0;
      ov = 0;
      tick = 1'b1;
      for (int c = 1; c <= 90; c++) begin
         @(posedge clk);
         #1;
         tick = (c == t2 || c == t3);
         dn += int'(done);
         ov += int'(over);
      end
   endtask
   initial begin
      int done_at, busy_n, done_n, n, dn, ov, rel_exp;
      rst = 1'b1;
      tick = 1'b0;
      control = '0;
      ad = '0;
      sr = '0;
      vidx = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_overrun", 32'(over), 0);
      check_all("rst_lvl");
      done_at = -1;
      busy_n = 0;
      done_n = 0;
      tick = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk);
         #1;
         if (c == 1) tick = 1'b0;
         if (done && done_at < 0) done_at = c;
         busy_n += int'(busy);
         done_n += int'(done);
      end
      check("done_latency", done_at, 34);
      check("busy_cycles", busy_n, 33);
      check("done_width", done_n, 1);
      model_pass();
      check_all("idle_pass");
      control[3] = 8'h01;
      ad[3] = 8'h00;
      sr[3] = 8'h80;
      repeat (255) do_pass();
      read_v3("attack_254", 254);
      do_pass();
      read_v3("attack_peak", 255);
      repeat (356) do_pass();
      read_v3("decay_pre_sustain", 'h89);
      do_pass();
      read_v3("decay_sustain", 'h88);
      repeat (100) do_pass();
      read_v3("sustain_hold", 'h88);
      control[3] = 8'h00;
      n = 0;
      while (m_lvl[3] != 'h40 && n < 5000) begin
         do_pass();
         n++;
      end
`ifdef ENV_EXP_DECAY_EN
      rel_exp = 304;
`else
      rel_exp = 217;
`endif
      check("release_ticks_to_40", n, rel_exp);
      read_v3("release_40", 'h40);
      control[3] = 8'h01;
      do_pass();
      read_v3("retrigger_hold", 'h40);
      do_pass();
      read_v3("retrigger_attack", 'h41);
      window(5, 0, dn, ov);
      check("b2b_dones", dn, 2);
      check("b2b_overrun", ov, 0);
      model_pass();
      model_pass();
      check_all("b2b_lvl");
      window(5, 15, dn, ov);
      check("ovr_dones", dn, 2);
      check("ovr_overrun", ov, 1);
      model_pass();
      model_pass();
      check_all("ovr_lvl");
      tick = 1'b1;
      @(posedge clk);
      #1;
      tick = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("mid_busy", 32'(busy), 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      check("midrst_busy", 32'(busy), 0);
      check("midrst_done", 32'(done), 0);
      check("midrst_overrun", 32'(over), 0);
      check_all("midrst_lvl");
      done_n = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         done_n += int'(done);
      end
      check("midrst_no_done", done_n, 0);
      repeat (200) begin
         for (int v = 0; v < 16; v++) begin
            if ($urandom_range(0, 7) == 0) control[v][0] = ~control[v][0];
            if ($urandom_range(0, 15) == 0) begin
               ad[v][7:4] = 4'($urandom_range(0, 2));
               ad[v][3:0] = 4'($urandom_range(0, 3));
               sr[v][3:0] = 4'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 15) == 0) sr[v][7:4] = 4'($urandom);
         end
         do_pass();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
